// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Brief    : Moore FSM controller for the multicycle MIPS datapath. Runs
//             each instruction over 3-5 cycles, with memready wait states,
//             illegal-instruction detection and a retire pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int OPWIDTH  = 6,
  parameter int FNWIDTH  = 6,
  parameter int ALUWIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPWIDTH-1:0]  op,
  input  logic [FNWIDTH-1:0]  funct,
  input  logic                zero,
  input  logic                memready,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                pcen,
  output logic [1:0]          pcsrc,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALUWIDTH-1:0] alucontrol,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                illegal,
  output logic                instr_done
);

  localparam logic [OPWIDTH-1:0]  C_OP_R    = OPWIDTH'(6'b000000);
  localparam logic [OPWIDTH-1:0]  C_OP_LW   = OPWIDTH'(6'b100011);
  localparam logic [OPWIDTH-1:0]  C_OP_SW   = OPWIDTH'(6'b101011);
  localparam logic [OPWIDTH-1:0]  C_OP_BEQ  = OPWIDTH'(6'b000100);
  localparam logic [OPWIDTH-1:0]  C_OP_BNE  = OPWIDTH'(6'b000101);
  localparam logic [OPWIDTH-1:0]  C_OP_ADDI = OPWIDTH'(6'b001000);
  localparam logic [OPWIDTH-1:0]  C_OP_J    = OPWIDTH'(6'b000010);

  localparam logic [FNWIDTH-1:0]  C_FN_ADD  = FNWIDTH'(6'b100000);
  localparam logic [FNWIDTH-1:0]  C_FN_SUB  = FNWIDTH'(6'b100010);
  localparam logic [FNWIDTH-1:0]  C_FN_AND  = FNWIDTH'(6'b100100);
  localparam logic [FNWIDTH-1:0]  C_FN_OR   = FNWIDTH'(6'b100101);
  localparam logic [FNWIDTH-1:0]  C_FN_SLT  = FNWIDTH'(6'b101010);

  localparam logic [ALUWIDTH-1:0] C_ALU_ADD = ALUWIDTH'(3'b010);
  localparam logic [ALUWIDTH-1:0] C_ALU_SUB = ALUWIDTH'(3'b110);
  localparam logic [ALUWIDTH-1:0] C_ALU_AND = ALUWIDTH'(3'b000);
  localparam logic [ALUWIDTH-1:0] C_ALU_OR  = ALUWIDTH'(3'b001);
  localparam logic [ALUWIDTH-1:0] C_ALU_SLT = ALUWIDTH'(3'b111);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_isbne;    // branch flavour captured in DECODE
  logic [ALUWIDTH-1:0]  r_execalu;  // R-type ALU op captured in DECODE
  logic                 w_fnlegal;
  logic [ALUWIDTH-1:0]  w_fnalu;
  logic                 w_memwrite;
  logic                 w_irwrite;
  logic                 w_pcen;
  logic                 w_regwrite;
  logic                 w_illegal;
  logic                 w_done;

  // R-type funct decode: ALU operation and legality
  always_comb begin
    w_fnlegal = 1'b1;
    w_fnalu   = C_ALU_ADD;
    case (funct)
      C_FN_ADD: w_fnalu = C_ALU_ADD;
      C_FN_SUB: w_fnalu = C_ALU_SUB;
      C_FN_AND: w_fnalu = C_ALU_AND;
      C_FN_OR:  w_fnalu = C_ALU_OR;
      C_FN_SLT: w_fnalu = C_ALU_SLT;
      default:  w_fnlegal = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Capture decode-time fields so later states ignore IR changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isbne   <= 1'b0;
      r_execalu <= C_ALU_ADD;
    end else if (r_state == S_DECODE) begin
      r_isbne   <= (op == C_OP_BNE);
      r_execalu <= w_fnalu;
    end
  end

  // Next-state and state-decoded datapath controls
  always_comb begin
    w_next     = S_FETCH;
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = C_ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcen    = memready;
        w_next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (op == C_OP_LW || op == C_OP_SW)        w_next = S_MEMADR;
        else if (op == C_OP_R && w_fnlegal)        w_next = S_EXECUTE;
        else if (op == C_OP_BEQ || op == C_OP_BNE) w_next = S_BRANCH;
        else if (op == C_OP_ADDI)                  w_next = S_ADDIEX;
        else if (op == C_OP_J)                     w_next = S_JUMP;
        else                                       w_next = S_ILLEGAL;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = memready;
        w_next     = memready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = r_execalu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = C_ALU_SUB;
        pcsrc      = 2'b01;
        w_pcen     = r_isbne ? ~zero : zero;
        w_done     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        w_pcen = 1'b1;
        w_done = 1'b1;
      end
      S_ILLEGAL: begin
        w_illegal = 1'b1;
        w_done    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables and pulses are held low while reset is asserted
  assign memwrite   = w_memwrite & ~reset;
  assign irwrite    = w_irwrite  & ~reset;
  assign pcen       = w_pcen     & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign illegal    = w_illegal  & ~reset;
  assign instr_done = w_done     & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Brief    : Directed self-checking bench for multicycle_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regdst, memtoreg, regwrite, illegal, instr_done;

  int checks;
  int errors;

  multicycle_controller #(.OPWIDTH(6), .FNWIDTH(6), .ALUWIDTH(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .illegal(illegal), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {iord,memwrite,irwrite,pcen,pcsrc,alusrca,alusrcb,alucontrol,
  //  regdst,memtoreg,regwrite,illegal,instr_done}
  logic [16:0] outs;
  assign outs = {iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
                 alucontrol, regdst, memtoreg, regwrite, illegal, instr_done};

  localparam logic [16:0] F1   = 17'b0_0_1_1_00_0_01_010_00000;
  localparam logic [16:0] F0   = 17'b0_0_0_0_00_0_01_010_00000;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_00_0_11_010_00000;
  localparam logic [16:0] MA   = 17'b0_0_0_0_00_1_10_010_00000;
  localparam logic [16:0] MR   = 17'b1_0_0_0_00_0_00_010_00000;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_00_0_00_010_01101;
  localparam logic [16:0] MW0  = 17'b1_1_0_0_00_0_00_010_00000;
  localparam logic [16:0] MW1  = 17'b1_1_0_0_00_0_00_010_00001;
  localparam logic [16:0] AWB  = 17'b0_0_0_0_00_0_00_010_10101;
  localparam logic [16:0] AIEX = 17'b0_0_0_0_00_1_10_010_00000;
  localparam logic [16:0] AIWB = 17'b0_0_0_0_00_0_00_010_00101;
  localparam logic [16:0] JMP  = 17'b0_0_0_1_10_0_00_010_00001;
  localparam logic [16:0] ILL  = 17'b0_0_0_0_00_0_00_010_00011;

  // Reset held: FETCH with write enables forced low, then release
  task automatic test_reset();
    reset = 1'b1; memready = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    #1;
    checks++;
    if (outs !== F0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", outs, F0);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // lw with memready tied high: 5 cycles
  task automatic test_lw();
    logic [16:0] exp [0:4];
    exp[0] = F1; exp[1] = DEC; exp[2] = MA; exp[3] = MR; exp[4] = MWB;
    op = 6'b100011; memready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // R-type; funct is scrambled after DECODE to prove it was captured
  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu);
    logic [16:0] exp [0:3];
    exp[0] = F1; exp[1] = DEC;
    exp[2] = {4'b0000, 2'b00, 1'b1, 2'b00, alu, 5'b00000};
    exp[3] = AWB;
    op = 6'b000000; funct = fn; memready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) funct = ~fn;
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL rtype fn=%b cycle %0d: got %b expected %b", fn, i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // beq/bne taken/not-taken
  task automatic test_branch(input logic [5:0] opc, input logic z, input logic taken);
    logic [16:0] exp [0:2];
    exp[0] = F1; exp[1] = DEC;
    exp[2] = {3'b000, taken, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00001};
    op = opc; zero = z; memready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL branch op=%b zero=%b cycle %0d: got %b expected %b", opc, z, i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // sw with 3 wait cycles in FETCH and 3 in MEMWR: 10 cycles
  task automatic test_sw_stall();
    logic [16:0] exp [0:9];
    logic        mr  [0:9];
    exp[0] = F0; exp[1] = F0; exp[2] = F0; exp[3] = F1; exp[4] = DEC;
    exp[5] = MA; exp[6] = MW0; exp[7] = MW0; exp[8] = MW0; exp[9] = MW1;
    mr[0] = 0; mr[1] = 0; mr[2] = 0; mr[3] = 1; mr[4] = 1;
    mr[5] = 1; mr[6] = 0; mr[7] = 0; mr[8] = 0; mr[9] = 1;
    op = 6'b101011;
    for (int i = 0; i < 10; i++) begin
      memready = mr[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL sw_stall cycle %0d: got %b expected %b", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // addi: 4 cycles
  task automatic test_addi();
    logic [16:0] exp [0:3];
    exp[0] = F1; exp[1] = DEC; exp[2] = AIEX; exp[3] = AIWB;
    op = 6'b001000; memready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL addi cycle %0d: got %b expected %b", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // j: 3 cycles
  task automatic test_jump();
    logic [16:0] exp [0:2];
    exp[0] = F1; exp[1] = DEC; exp[2] = JMP;
    op = 6'b000010; memready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL jump cycle %0d: got %b expected %b", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Unsupported op or funct: 3 cycles, single illegal pulse, no writes
  task automatic test_illegal(input logic [5:0] opc, input logic [5:0] fn);
    logic [16:0] exp [0:2];
    exp[0] = F1; exp[1] = DEC; exp[2] = ILL;
    op = opc; funct = fn; memready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL illegal op=%b fn=%b cycle %0d: got %b expected %b", opc, fn, i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Async reset in MEMWR: memwrite drops without a clock edge
  task automatic test_async_reset();
    logic [16:0] exp [0:3];
    exp[0] = F1; exp[1] = DEC; exp[2] = MA; exp[3] = MW0;
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      memready = (i == 3) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL async_reset seq cycle %0d: got %b expected %b", i, outs, exp[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1;
    memready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0) begin
      errors++;
      $display("FAIL async_reset memwrite: got %b expected 0", memwrite);
    end
    checks++;
    if (outs !== F0) begin
      errors++;
      $display("FAIL async_reset state: got %b expected %b", outs, F0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== F1) begin
      errors++;
      $display("FAIL async_reset release: got %b expected %b", outs, F1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b100100, 3'b000);
    test_rtype(6'b100101, 3'b001);
    test_rtype(6'b101010, 3'b111);
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_sw_stall();
    test_addi();
    test_jump();
    test_illegal(6'b111111, 6'b100000);
    test_illegal(6'b000000, 6'b000111);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM controller for the multicycle MIPS datapath; successor to the single-cycle controller.
- Sequences each instruction over 3-5 cycles and drives the datapath enables and muxes; the main/ALU decoding is folded into the state logic.
- Adds bne, stall-on-memory handshake (memready wait states), illegal-instruction detection and an instruction-retire pulse.
- Sits between the instruction register (op/funct) and the shared-memory datapath.

Parameters:
OPWIDTH, 6, opcode field width
FNWIDTH, 6, funct field width
ALUWIDTH, 3, alucontrol width (010 add, 110 sub, 000 and, 001 or, 111 slt)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; state -> FETCH
op  in  OPWIDTH  IR opcode
funct  in  FNWIDTH  IR funct
zero  in  1  ALU zero flag
memready  in  1  memory access completes this cycle
iord  out  1  address mux: 0 PC, 1 ALUOut
memwrite  out  1  memory write enable
irwrite  out  1  IR load enable
pcen  out  1  PC enable = pcwrite | (beq & zero) | (bne & ~zero)
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alusrca  out  1  0 PC, 1 rs
alusrcb  out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
alucontrol  out  ALUWIDTH  ALU op
regdst  out  1  0 rt, 1 rd
memtoreg  out  1  0 ALUOut, 1 Data
regwrite  out  1  register file write enable
illegal  out  1  one-cycle pulse on unsupported op/funct
instr_done  out  1  one-cycle pulse in final cycle of each instruction

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010. R funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Outputs are decoded from state only, except the memready gating listed below. Every output not listed for a state is 0; alucontrol defaults to 010.
- While reset is high: state = FETCH and memwrite, irwrite, pcen, regwrite, illegal, instr_done are forced 0.
- FETCH: iord=0, alusrcb=01, add. irwrite=pcen=memready. Stays in FETCH until memready=1, then -> DECODE.
- DECODE: alusrcb=11, add (precomputes branch target).
  - lw/sw -> MEMADR; R with legal funct -> EXECUTE; beq/bne -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Anything else -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Waits for memready, then -> MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 held every wait cycle. When memready=1: instr_done=1, -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen=zero for beq, ~zero for bne. instr_done=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1 -> FETCH.
- ILLEGAL: illegal=1, instr_done=1, no architectural writes -> FETCH (instruction skipped; PC already advanced).
- Latency in cycles with memready tied 1: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 3. Each memready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- op/funct are sampled only in DECODE and MEMADR; changes at other times have no effect.
- Reset asserted mid-instruction aborts it immediately; the first post-reset cycle is FETCH.
- Unused state encodings -> FETCH.

Test Plan:
- Reset held, then released with memready=1, op=lw -> FETCH (irwrite=pcen=1), DECODE, MEMADR (alusrcb=10), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1, instr_done=1); 5 cycles.
- R-type sub (funct 100010) -> EXECUTE alucontrol=110, ALUWB regdst=1 regwrite=1. Repeat for and/or/slt -> 000/001/111.
- beq zero=1 -> pcen=1 in BRANCH; beq zero=0 -> pcen=0. bne zero=0 -> pcen=1; bne zero=1 -> pcen=0. pcsrc=01 in all four cases.
- memready=0 for 3 cycles in FETCH, then in MEMWR during sw -> irwrite/pcen stay 0 until memready. memwrite=1 for all 4 MEMWR cycles. Total 4+6=10 cycles.
- op=111111, then R with funct 000111 -> illegal pulse 1 cycle, no regwrite/memwrite, return to FETCH. j -> pcsrc=10, pcen=1, 3 cycles.
- Reset asserted asynchronously in MEMWR with memwrite=1 -> memwrite drops within the same cycle; state FETCH after release.
